stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 108 ++++++++++
 tb/tb_stage_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle fetch/decode/execute/memory/writeback/pc-update control FSM
// with a registered status code, halt flag and retired-instruction counter.
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic             cc_we,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPDATE, S_STOP
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state, w_next;
    logic [2:0]       r_stat, w_stat;
    logic [5:0]       r_en, w_en;
    logic             r_cc_we, r_halted;
    logic [3:0]       r_icode;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;
    logic             w_is_mem;

    assign w_is_mem = r_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    always_comb begin
        w_next = r_state;
        w_stat = (r_state == S_STOP) ? r_stat : STAT_AOK;
        case (r_state)
            S_IDLE:      w_next = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                w_next = S_STOP;
                if (imem_error) w_stat = STAT_ADR;
                else if (!instr_valid || icode > 4'hB) w_stat = STAT_INS;
                else if (icode == 4'h0) w_stat = STAT_HLT;
                else w_next = S_DECODE;
            end
            S_DECODE:    w_next = S_EXECUTE;
            S_EXECUTE:   w_next = w_is_mem ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                // an ack arriving on the last allowed cycle beats the timeout
                if (mem_ack ? dmem_error : (r_wait == WAIT_LAST)) begin
                    w_next = S_STOP;
                    w_stat = STAT_ADR;
                end else if (mem_ack) begin
                    w_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: w_next = S_PCUPDATE;
            S_PCUPDATE:  w_next = S_FETCH;
            default:     w_next = S_STOP;
        endcase
    end

    assign w_en = {w_next == S_PCUPDATE, w_next == S_WRITEBACK, w_next == S_MEMORY,
                   w_next == S_EXECUTE, w_next == S_DECODE, w_next == S_FETCH};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_en      <= '0;
            r_cc_we   <= 1'b0;
            r_halted  <= 1'b0;
            r_stat    <= STAT_AOK;
            r_icode   <= 4'h0;
            r_wait    <= 8'd0;
            r_retired <= '0;
        end else begin
            r_state  <= w_next;
            r_en     <= w_en;
            r_cc_we  <= (w_next == S_EXECUTE) && (r_icode == 4'h6);
            r_halted <= w_next == S_STOP;
            r_stat   <= w_stat;
            if (r_state == S_FETCH) r_icode <= icode;
            r_wait   <= (r_state == S_MEMORY && !mem_ack) ? r_wait + 8'd1 : 8'd0;
            if (r_state == S_PCUPDATE) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign {pc_en, writeback_en, memory_en, execute_en, decode_en, fetch_en} = r_en;
    assign mem_req = r_en[3];
    assign cc_we   = r_cc_we;
    assign stat    = r_stat;
    assign halted  = r_halted;
    assign retired = r_retired;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: scoreboard bench; each queued entry holds the expected outputs
// for one cycle plus the inputs to drive during that cycle.
module tb_stage_sequencer;
    localparam int MT = 4;
    localparam int CW = 4;
    localparam logic [5:0] F_EN = 6'd1, D_EN = 6'd2, E_EN = 6'd4, M_EN = 6'd8, W_EN = 6'd16, P_EN = 6'd32;
    localparam logic [15:0] RST_W = {4'd0, 1'b0, 3'd1, 1'b0, 1'b0, 6'd0};

    typedef struct packed {
        logic [15:0] exp;
        logic        st;
        logic [3:0]  ic;
        logic        iv;
        logic        ie;
        logic        ack;
        logic        de;
    } ent_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, instr_valid = 1'b1;
    logic imem_error = 1'b0, mem_ack = 1'b0, dmem_error = 1'b0;
    logic [3:0] icode = 4'h0;
    logic fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en, cc_we, mem_req, halted;
    logic [2:0] stat;
    logic [CW-1:0] retired;
    logic [15:0] obs;
    ent_t sb[$];
    int checks = 0, failures = 0, mret = 0;

    stage_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en), .memory_en(memory_en),
        .writeback_en(writeback_en), .pc_en(pc_en), .cc_we(cc_we), .mem_req(mem_req),
        .stat(stat), .halted(halted), .retired(retired)
    );

    assign obs = {retired, halted, stat, mem_req, cc_we, pc_en, writeback_en, memory_en, execute_en, decode_en, fetch_en};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] ew(logic [5:0] en, logic cc, logic h, logic [2:0] st);
        return {4'(mret), h, st, en[3], cc, en};
    endfunction

    task automatic push(input logic [15:0] exp, input logic st, input logic [3:0] ic, input logic iv,
                        input logic ie, input logic ack, input logic de);
        sb.push_back({exp, st, ic, iv, ie, ack, de});
    endtask

    task automatic push_stop(input logic [2:0] st, input logic strt);
        push(ew(6'd0, 1'b0, 1'b1, st), strt, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic push_fetch();
        push(ew(F_EN, 1'b0, 1'b0, 3'd1), 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference model of one instruction; nz drives mem_ack/dmem_error where they must be ignored.
    task automatic push_instr(input logic [3:0] ic, input int ack_at, input logic de, input logic iv,
                              input logic ie, input logic nz);
        logic done, stp;
        done = 1'b0;
        stp = 1'b0;
        push(ew(F_EN, 1'b0, 1'b0, 3'd1), 1'b0, ic, iv, ie, nz, nz);
        if (ie) push_stop(3'd3, 1'b0);
        else if (!iv || ic > 4'hB) push_stop(3'd4, 1'b0);
        else if (ic == 4'h0) push_stop(3'd2, 1'b0);
        else begin
            push(ew(D_EN, 1'b0, 1'b0, 3'd1), 1'b0, ic, 1'b1, 1'b0, nz, nz);
            push(ew(E_EN, ic == 4'h6, 1'b0, 3'd1), 1'b0, ic, 1'b1, 1'b0, nz, nz);
            if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                for (int i = 0; i < MT && !done; i++) begin
                    if (i == ack_at) begin
                        push(ew(M_EN, 1'b0, 1'b0, 3'd1), 1'b0, ic, 1'b1, 1'b0, 1'b1, de);
                        done = 1'b1;
                        stp = de;
                    end else begin
                        push(ew(M_EN, 1'b0, 1'b0, 3'd1), 1'b0, ic, 1'b1, 1'b0, 1'b0, nz);
                        if (i == MT - 1) begin
                            done = 1'b1;
                            stp = 1'b1;
                        end
                    end
                end
            end
            if (stp) push_stop(3'd3, 1'b0);
            else begin
                push(ew(W_EN, 1'b0, 1'b0, 3'd1), 1'b0, ic, 1'b1, 1'b0, nz, nz);
                push(ew(P_EN, 1'b0, 1'b0, 3'd1), 1'b0, ic, 1'b1, 1'b0, nz, nz);
                mret++;
            end
        end
    endtask

    task automatic drive(input ent_t x);
        start = x.st;
        icode = x.ic;
        instr_valid = x.iv;
        imem_error = x.ie;
        mem_ack = x.ack;
        dmem_error = x.de;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive({16'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        mret = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== RST_W) begin failures++; $display("FAIL reset_state: obs=%h exp=%h", obs, RST_W); end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== RST_W) begin failures++; $display("FAIL idle_hold: obs=%h exp=%h", obs, RST_W); end
    endtask

    task automatic test_op();
        ent_t x;
        do_reset();
        push_instr(4'h6, -1, 1'b0, 1'b1, 1'b0, 1'b1);
        push_fetch();
        start = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs !== x.exp) begin failures++; $display("FAIL op_cycle: obs=%h exp=%h", obs, x.exp); end
            drive(x);
        end
    endtask

    task automatic test_mem();
        ent_t x;
        do_reset();
        push_instr(4'h5, 2, 1'b0, 1'b1, 1'b0, 1'b1);
        push_fetch();
        start = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs !== x.exp) begin failures++; $display("FAIL mem_cycle: obs=%h exp=%h", obs, x.exp); end
            drive(x);
        end
    endtask

    task automatic test_halt();
        ent_t x;
        do_reset();
        push_instr(4'h2, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_instr(4'h0, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) push_stop(3'd2, 1'b1);
        start = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs !== x.exp) begin failures++; $display("FAIL halt_cycle: obs=%h exp=%h", obs, x.exp); end
            drive(x);
        end
    endtask

    task automatic test_illegal();
        ent_t x;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            push_instr((k == 0) ? 4'hC : 4'h6, -1, 1'b0, k != 1, k == 2, 1'b0);
            push_stop((k == 2) ? 3'd3 : 3'd4, 1'b1);
            start = 1'b1;
            while (sb.size() > 0) begin
                @(negedge clk);
                x = sb.pop_front();
                checks++;
                if (obs !== x.exp) begin failures++; $display("FAIL illegal_%0d: obs=%h exp=%h", k, obs, x.exp); end
                drive(x);
            end
        end
    endtask

    task automatic test_timeout();
        ent_t x;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            case (k)
                0: push_instr(4'hA, -1, 1'b0, 1'b1, 1'b0, 1'b1);
                1: push_instr(4'hA, MT - 1, 1'b0, 1'b1, 1'b0, 1'b1);
                2: push_instr(4'h4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
                default: push_instr(4'hB, 0, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            if (k == 0 || k == 2) push_stop(3'd3, 1'b1);
            else push_fetch();
            start = 1'b1;
            while (sb.size() > 0) begin
                @(negedge clk);
                x = sb.pop_front();
                checks++;
                if (obs !== x.exp) begin failures++; $display("FAIL timeout_%0d: obs=%h exp=%h", k, obs, x.exp); end
                drive(x);
            end
        end
    endtask

    task automatic test_reset_mid();
        ent_t x;
        logic [15:0] fw;
        do_reset();
        push_instr(4'h2, -1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_instr(4'h8, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        push(ew(F_EN, 1'b0, 1'b0, 3'd1), 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(ew(D_EN, 1'b0, 1'b0, 3'd1), 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(ew(E_EN, 1'b1, 1'b0, 3'd1), 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs !== x.exp) begin failures++; $display("FAIL mid_cycle: obs=%h exp=%h", obs, x.exp); end
            drive(x);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RST_W) begin failures++; $display("FAIL async_reset: obs=%h exp=%h", obs, RST_W); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== RST_W) begin failures++; $display("FAIL wait_start: obs=%h exp=%h", obs, RST_W); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mret = 0;
        fw = ew(F_EN, 1'b0, 1'b0, 3'd1);
        checks++;
        if (obs !== fw) begin failures++; $display("FAIL restart: obs=%h exp=%h", obs, fw); end
    endtask

    task automatic test_back_to_back();
        ent_t x;
        logic [3:0] prog [16];
        prog = '{4'h1, 4'h2, 4'h6, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'hC - 4'h1, 4'h1, 4'h5, 4'h2};
        do_reset();
        for (int k = 0; k < 16; k++) push_instr(prog[k], k % 3, 1'b0, 1'b1, 1'b0, k[0]);
        push_fetch();
        start = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if (obs !== x.exp) begin failures++; $display("FAIL b2b_cycle: obs=%h exp=%h", obs, x.exp); end
            drive(x);
        end
        checks++;
        if (retired !== 4'd0) begin failures++; $display("FAIL retired_wrap: obs=%0d exp=0", retired); end
    endtask

    initial begin
        test_reset();
        test_op();
        test_mem();
        test_halt();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
